neuron_learn_layer_seq: RTL

NEURON_LEARN_LAYER_SEQ -- requirements
Module: neuron_learn_layer_seq

---
 rtl/neuron_learn_layer_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/neuron_learn_layer_seq.sv
// Sequential single-layer neuron block: time-multiplexed forward MAC over all
// neurons, optional backward pass that updates weights and produces averaged
// back-propagated input targets.
module neuron_learn_layer_seq #(
    parameter int unsigned N        = 16,
    parameter int unsigned M        = 42,
    parameter int unsigned LR_SHIFT = 2,
    localparam int unsigned MW      = (M > 1) ? $clog2(M) : 1,
    localparam int unsigned NW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                learn,
    input  logic [N-1:0][7:0]   in,
    input  logic [M-1:0][7:0]   expected_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M-1:0][7:0]   out,
    output logic [N-1:0][7:0]   expected_in,
    input  logic                wr_en,
    input  logic [MW-1:0]       wr_neuron,
    input  logic [NW-1:0]       wr_input,
    input  logic [15:0]         wr_data,
    input  logic [MW-1:0]       rd_neuron,
    input  logic [NW-1:0]       rd_input,
    output logic [15:0]         rd_data,
    output logic                busy
);

    localparam int unsigned ACC_W = 25 + NW;
    localparam int unsigned SUM_W = 8 + $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, FORWARD, BACKWARD, DONE} state_t;

    state_t                    state;
    logic signed [15:0]        w [M][N];
    logic [N-1:0][7:0]         in_q;
    logic [M-1:0][7:0]         exp_q;
    logic                      learn_q;
    logic [MW-1:0]             m_idx;
    logic [NW-1:0]             n_idx;
    logic signed [ACC_W-1:0]   acc;
    logic [SUM_W-1:0]          sum_q [N];

    logic                      last_n;
    logic                      last_m;
    logic signed [15:0]        w_cur;
    logic signed [8:0]         in_s;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   act;
    logic [7:0]                act_sat;
    logic signed [8:0]         err;
    logic signed [31:0]        dw;
    logic signed [31:0]        w_sum;
    logic signed [15:0]        w_new;
    logic signed [31:0]        corr;
    logic signed [31:0]        c_full;
    logic [7:0]                c8;
    logic [SUM_W-1:0]          sum_next [N];

    // Handshake and status decode; reset forces the idle view immediately
    assign in_ready  = reset | ((state == IDLE) & ~wr_en);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Combinational weight read port, zero for out-of-range addresses
    always_comb begin
        rd_data = '0;
        if (32'(rd_neuron) < M && 32'(rd_input) < N)
            rd_data = w[rd_neuron][rd_input];
    end

    // Shared datapath: forward MAC with activation clamp, backward weight
    // update and per-input target contribution
    always_comb begin
        last_n   = (n_idx == NW'(N - 1));
        last_m   = (m_idx == MW'(M - 1));
        w_cur    = w[m_idx][n_idx];
        in_s     = $signed({1'b0, in_q[n_idx]});
        acc_next = acc + ACC_W'(in_s) * ACC_W'(w_cur);
        act      = acc_next >>> 8;
        if (act < ACC_W'(0))
            act_sat = 8'd0;
        else if (act > ACC_W'(255))
            act_sat = 8'd255;
        else
            act_sat = act[7:0];

        err   = $signed({1'b0, exp_q[m_idx]}) - $signed({1'b0, out[m_idx]});
        dw    = (32'(err) * 32'(in_s)) >>> (8 + LR_SHIFT);
        w_sum = 32'(w_cur) + dw;
        if (w_sum > 32'sd32767)
            w_new = 16'sh7fff;
        else if (w_sum < -32'sd32768)
            w_new = -16'sh8000;
        else
            w_new = w_sum[15:0];

        corr   = (32'(err) * 32'(w_cur)) >>> 8;
        c_full = 32'(in_s) + corr;
        if (c_full < 32'sd0)
            c8 = 8'd0;
        else if (c_full > 32'sd255)
            c8 = 8'd255;
        else
            c8 = c_full[7:0];

        for (int k = 0; k < N; k++)
            sum_next[k] = sum_q[k];
        sum_next[n_idx] = sum_q[n_idx] + SUM_W'(c8);
    end

    // Control FSM with weight store, accumulator, counters and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_q        <= '0;
            exp_q       <= '0;
            learn_q     <= 1'b0;
            m_idx       <= '0;
            n_idx       <= '0;
            acc         <= '0;
            out         <= '0;
            expected_in <= '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    w[i][j] <= '0;
            for (int k = 0; k < N; k++)
                sum_q[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (32'(wr_neuron) < M && 32'(wr_input) < N)
                            w[wr_neuron][wr_input] <= wr_data;
                    end else if (in_valid) begin
                        in_q    <= in;
                        exp_q   <= expected_out;
                        learn_q <= learn;
                        acc     <= '0;
                        m_idx   <= '0;
                        n_idx   <= '0;
                        for (int k = 0; k < N; k++)
                            sum_q[k] <= '0;
                        state   <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (last_n) begin
                        out[m_idx] <= act_sat;
                        acc        <= '0;
                        n_idx      <= '0;
                        if (last_m) begin
                            m_idx <= '0;
                            if (learn_q) begin
                                state <= BACKWARD;
                            end else begin
                                expected_in <= in_q;
                                state       <= DONE;
                            end
                        end else begin
                            m_idx <= m_idx + MW'(1);
                        end
                    end else begin
                        acc   <= acc_next;
                        n_idx <= n_idx + NW'(1);
                    end
                end
                BACKWARD: begin
                    w[m_idx][n_idx] <= w_new;
                    for (int k = 0; k < N; k++)
                        sum_q[k] <= sum_next[k];
                    if (last_n) begin
                        n_idx <= '0;
                        if (last_m) begin
                            m_idx <= '0;
                            for (int k = 0; k < N; k++)
                                expected_in[k] <= 8'(sum_next[k] / SUM_W'(M));
                            state <= DONE;
                        end else begin
                            m_idx <= m_idx + MW'(1);
                        end
                    end else begin
                        n_idx <= n_idx + NW'(1);
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
